piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//   Parallel-in/serial-out word serializer with valid/ready load handshake.
//   Sits directly upstream of the 4-bit serial shift register stage.
//   Sout drives that stage's D input, so a word loaded here reappears in
//   its Q after WIDTH valid clocks.
//   Adds framing (Frame_start) and an optional inter-word gap.
// PARAMETERS
//   WIDTH       4  data bits per word (>=2)
//   MSB_FIRST   1  1: Data_in[WIDTH-1] goes out first; 0: Data_in[0] goes out first
//   GAP_CYCLES  1  idle clocks forced between words (0..15)
// PORTS
//   Clk          in   1      rising-edge clock
//   Rst_n        in   1      asynchronous reset, active-low
//   Data_in      in   WIDTH  parallel word, sampled only on accept
//   Load_valid   in   1      producer offers Data_in
//   Load_ready   out  1      block can accept a word this cycle
//   Sout         out  1      serial data bit (to downstream D)
//   Sout_valid   out  1      Sout carries a real bit this cycle
//   Frame_start  out  1      high with the first bit of each word
//   Busy         out  1      state != IDLE
// BEHAVIOUR
//   Reset (Rst_n=0, async, takes effect immediately):
//   - Sout=0, Sout_valid=0, Frame_start=0, Busy=0, Load_ready=1.
//   - state=IDLE; bit counter and shift register cleared.
//   Accept = Load_valid & Load_ready at a rising Clk edge.
//   FSM states: IDLE, SHIFT, GAP.
//   - IDLE -> SHIFT on accept. Data_in is captured into the shift register.
//   - SHIFT: bit k of the frame (k=1..N) is on Sout in the k-th cycle
//     after accept (latency 1 clock).
//   - N = WIDTH, or WIDTH+1 with parity. Sout_valid=1 for all N cycles.
//   - Frame_start=1 only in the cycle carrying bit 1.
//   - SHIFT -> GAP after bit N when GAP_CYCLES>0.
//   - GAP lasts exactly GAP_CYCLES clocks: Sout=0, Sout_valid=0. GAP -> IDLE.
//   - GAP_CYCLES=0: SHIFT -> IDLE after bit N, or SHIFT -> SHIFT if a new word
//     is accepted in the bit-N cycle. That gives back-to-back frames with no
//     idle bit.
//   Load_ready = (state==IDLE) | (state==SHIFT & last bit & GAP_CYCLES==0).
//   Load_valid while Load_ready=0: ignored; Data_in is not sampled.
//   Bit counter: at least 5 bits wide. Counts 1..N and wraps to 0 on frame end.
//   Outputs are registered except Load_ready and Busy (decoded from state).
//   Rst_n asserted mid-frame: the partial word is discarded, no further
//   valid bits. After release, state is IDLE and the next accept starts a
//   clean frame.
// CONFIGURATION
//   Macro PISO_PARITY_EN:
//   - Defined: one extra bit is sent after the data bits, with
//     Sout_valid=1 and Frame_start=0.
//   - That bit is even parity, ^Data_in as captured at accept. N=WIDTH+1.
//   - Not defined: no parity logic. N=WIDTH. Ports are unchanged in
//     both builds.
// TESTING
//   Setup: Clk period 10 ns; downstream 4-bit shift register instantiated
//   on Sout.
//   1. Reset, then accept 4'b1011 (MSB_FIRST=1).
//      -> Sout=1,0,1,1 on cycles 1-4, Sout_valid high 4 cycles,
//         Frame_start on cycle 1 only.
//      -> Downstream Q=4'b1011 after cycle 4.
//   2. MSB_FIRST=0, accept 4'b0001.
//      -> Sout=1,0,0,0. Busy high 4+GAP_CYCLES cycles.
//   3. GAP_CYCLES=2, Load_valid held high with 4'hF during frame 4'h3.
//      -> Load_ready=0 for 6 cycles, then 4'hF is accepted.
//      -> Sout_valid low exactly 2 cycles between frames.
//   4. GAP_CYCLES=0, words 4'hA then 4'h5 offered back-to-back.
//      -> 8 contiguous valid bits 1,0,1,0,0,1,0,1.
//      -> Frame_start on bits 1 and 5.
//   5. Rst_n pulsed low during bit 2 of 4'hC.
//      -> Sout and Sout_valid go 0 without a clock edge, Load_ready=1.
//      -> A new accept of 4'h9 yields 1,0,0,1.
//   6. PISO_PARITY_EN defined, accept 4'b0111 (MSB_FIRST=1).
//      -> Sout=0,1,1,1,1 with Sout_valid high 5 cycles.
//      -> Accept 4'b0011 gives parity bit 0.

Source files
------------

// File: rtl/piso_serializer_if.sv
// piso_serializer_if
//   Load handshake and serial output bundle for piso_serializer.
//   master : producer/consumer side (drives Data_in, Load_valid)
//   slave  : the serializer (drives Load_ready, Sout, Sout_valid,
//            Frame_start, Busy)
// Signals
//   Data_in      WIDTH  parallel word, sampled only on accept
//   Load_valid   1      producer offers Data_in
//   Load_ready   1      serializer can accept a word this cycle
//   Sout         1      serial data bit
//   Sout_valid   1      Sout carries a real bit this cycle
//   Frame_start  1      high with the first bit of each word
//   Busy         1      serializer not idle
interface piso_serializer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] Data_in;
  logic             Load_valid;
  logic             Load_ready;
  logic             Sout;
  logic             Sout_valid;
  logic             Frame_start;
  logic             Busy;

  modport master (
    output Data_in, Load_valid,
    input  Load_ready, Sout, Sout_valid, Frame_start, Busy
  );

  modport slave (
    input  Data_in, Load_valid,
    output Load_ready, Sout, Sout_valid, Frame_start, Busy
  );
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer
//   Parallel-in/serial-out word serializer with a valid/ready load
//   handshake, per-word framing and an optional forced inter-word gap.
//   The first bit of a word appears on Sout in the cycle after accept.
// Parameters
//   WIDTH       data bits per word (>=2)
//   MSB_FIRST   1: Data_in[WIDTH-1] first; 0: Data_in[0] first
//   GAP_CYCLES  idle clocks forced between words (0..15)
// Ports
//   Clk    rising-edge clock
//   Rst_n  asynchronous active-low reset
//   bus    piso_serializer_if.slave (Data_in, Load_valid, Load_ready,
//          Sout, Sout_valid, Frame_start, Busy)
// Build option
//   PISO_PARITY_EN  defined: an even-parity bit of the captured word is
//                   sent after the data bits (frame = WIDTH+1 bits).
module piso_serializer #(
  parameter int WIDTH      = 4,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 1
) (
  input logic             Clk,
  input logic             Rst_n,
  piso_serializer_if.slave bus
);

`ifdef PISO_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = ($clog2(NBITS + 1) > 5) ? $clog2(NBITS + 1) : 5;
  localparam logic [CW-1:0] LAST_CNT = CW'(NBITS);
`ifdef PISO_PARITY_EN
  localparam logic [CW-1:0] DATA_LAST_CNT = CW'(WIDTH);
`endif
  localparam bit       HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [3:0] GAP_LAST = HAS_GAP ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    bit_cnt;
  logic [3:0]       gap_cnt;
  logic             sout_q, sout_valid_q, frame_start_q;
`ifdef PISO_PARITY_EN
  logic             parity_q;
`endif

  logic             last_bit, load_ready, accept;
  logic             first_bit, next_bit;
  logic [WIDTH-1:0] load_rest, sreg_rest;

  assign last_bit   = (state == SHIFT) && (bit_cnt == LAST_CNT);
  assign load_ready = (state == IDLE) || (last_bit && !HAS_GAP);
  assign accept     = bus.Load_valid && load_ready;

  // The first bit goes straight to Sout on accept; sreg keeps the rest,
  // pre-shifted so the next bit to send always sits at the exit end.
  always_comb begin
    if (MSB_FIRST != 0) begin
      first_bit = bus.Data_in[WIDTH-1];
      load_rest = {bus.Data_in[WIDTH-2:0], 1'b0};
      next_bit  = sreg[WIDTH-1];
      sreg_rest = {sreg[WIDTH-2:0], 1'b0};
    end else begin
      first_bit = bus.Data_in[0];
      load_rest = {1'b0, bus.Data_in[WIDTH-1:1]};
      next_bit  = sreg[0];
      sreg_rest = {1'b0, sreg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = SHIFT;
      SHIFT: begin
        if (last_bit) begin
          if (HAS_GAP)     state_nxt = GAP;
          else if (accept) state_nxt = SHIFT;
          else             state_nxt = IDLE;
        end
      end
      GAP:     if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sreg          <= '0;
      bit_cnt       <= '0;
      gap_cnt       <= '0;
      sout_q        <= 1'b0;
      sout_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q      <= 1'b0;
`endif
    end else begin
      gap_cnt <= (state == GAP) ? gap_cnt + 4'd1 : 4'd0;
      if (accept) begin
        sreg          <= load_rest;
        bit_cnt       <= CW'(1);
        sout_q        <= first_bit;
        sout_valid_q  <= 1'b1;
        frame_start_q <= 1'b1;
`ifdef PISO_PARITY_EN
        parity_q      <= ^bus.Data_in;
`endif
      end else if ((state == SHIFT) && !last_bit) begin
        sreg          <= sreg_rest;
        bit_cnt       <= bit_cnt + CW'(1);
        sout_valid_q  <= 1'b1;
        frame_start_q <= 1'b0;
`ifdef PISO_PARITY_EN
        sout_q        <= (bit_cnt == DATA_LAST_CNT) ? parity_q : next_bit;
`else
        sout_q        <= next_bit;
`endif
      end else begin
        bit_cnt       <= '0;
        sout_q        <= 1'b0;
        sout_valid_q  <= 1'b0;
        frame_start_q <= 1'b0;
      end
    end
  end

  assign bus.Load_ready  = load_ready;
  assign bus.Busy        = (state != IDLE);
  assign bus.Sout        = sout_q;
  assign bus.Sout_valid  = sout_valid_q;
  assign bus.Frame_start = frame_start_q;

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer
//   Directed bench for piso_serializer. Four instances cover the
//   parameter sets needed (MSB/LSB first, gap 1/2/0); expectations follow
//   PISO_PARITY_EN when the bench is built with it.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int NB = 5;
  localparam logic [9:0] B2B = 10'b1010001010;
  localparam logic [3:0] Q_T1 = 4'b0111;
  localparam logic [4:0] T3_SEEN = 5'b00110;
`else
  localparam int NB = 4;
  localparam logic [9:0] B2B = 10'b0010100101;
  localparam logic [3:0] Q_T1 = 4'b1011;
  localparam logic [4:0] T3_SEEN = 5'b00011;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] din [4];
  logic       lv  [4];
  logic       so  [4];
  logic       sv  [4];
  logic       fs  [4];
  logic       rdy [4];
  logic       bsy [4];
  logic [3:0] q0 = 4'b0000;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(4)) if_a ();
  piso_serializer_if #(.WIDTH(4)) if_b ();
  piso_serializer_if #(.WIDTH(4)) if_c ();
  piso_serializer_if #(.WIDTH(4)) if_d ();

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1), .GAP_CYCLES(1)) dut_a (.Clk(clk), .Rst_n(rst_n), .bus(if_a));
  piso_serializer #(.WIDTH(4), .MSB_FIRST(0), .GAP_CYCLES(1)) dut_b (.Clk(clk), .Rst_n(rst_n), .bus(if_b));
  piso_serializer #(.WIDTH(4), .MSB_FIRST(1), .GAP_CYCLES(2)) dut_c (.Clk(clk), .Rst_n(rst_n), .bus(if_c));
  piso_serializer #(.WIDTH(4), .MSB_FIRST(1), .GAP_CYCLES(0)) dut_d (.Clk(clk), .Rst_n(rst_n), .bus(if_d));

  assign if_a.Data_in = din[0]; assign if_a.Load_valid = lv[0];
  assign if_b.Data_in = din[1]; assign if_b.Load_valid = lv[1];
  assign if_c.Data_in = din[2]; assign if_c.Load_valid = lv[2];
  assign if_d.Data_in = din[3]; assign if_d.Load_valid = lv[3];

  assign so[0] = if_a.Sout; assign sv[0] = if_a.Sout_valid; assign fs[0] = if_a.Frame_start;
  assign rdy[0] = if_a.Load_ready; assign bsy[0] = if_a.Busy;
  assign so[1] = if_b.Sout; assign sv[1] = if_b.Sout_valid; assign fs[1] = if_b.Frame_start;
  assign rdy[1] = if_b.Load_ready; assign bsy[1] = if_b.Busy;
  assign so[2] = if_c.Sout; assign sv[2] = if_c.Sout_valid; assign fs[2] = if_c.Frame_start;
  assign rdy[2] = if_c.Load_ready; assign bsy[2] = if_c.Busy;
  assign so[3] = if_d.Sout; assign sv[3] = if_d.Sout_valid; assign fs[3] = if_d.Frame_start;
  assign rdy[3] = if_d.Load_ready; assign bsy[3] = if_d.Busy;

  // Downstream 4-bit shift register fed by dut_a
  always @(posedge clk) if (sv[0]) q0 <= {q0[2:0], so[0]};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word; returns in the first bit cycle of the frame
  task automatic send(input int i, input logic [3:0] w);
    din[i] = w;
    lv[i]  = 1'b1;
    check("load_ready", rdy[i], 1);
    tick();
    lv[i]  = 1'b0;
  endtask

  // seq: data bits in transmission order (MSB = first), par: parity bit
  task automatic expect_frame(input int i, input string tag, input logic [3:0] seq, input logic par);
    logic e;
    for (int k = 0; k < NB; k++) begin
      e = (k < 4) ? seq[3-k] : par;
      check({tag, "_sout"},  so[i],  e);
      check({tag, "_valid"}, sv[i],  1);
      check({tag, "_fs"},    fs[i],  (k == 0) ? 1 : 0);
      check({tag, "_busy"},  bsy[i], 1);
      tick();
    end
  endtask

  task automatic wait_idle(input int i);
    for (int g = 0; g < 40 && bsy[i]; g++) tick();
    check("idle_timeout", bsy[i], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         cnt, low;
    logic [4:0] seen;
    for (int i = 0; i < 4; i++) begin
      din[i] = 4'h0;
      lv[i]  = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("rst_sout",  so[i],  0);
      check("rst_valid", sv[i],  0);
      check("rst_fs",    fs[i],  0);
      check("rst_busy",  bsy[i], 0);
      check("rst_ready", rdy[i], 1);
    end
    rst_n = 1'b1;
    tick();

    // 1: MSB first, 1011, downstream register capture, one-cycle gap
    send(0, 4'b1011);
    expect_frame(0, "t1", 4'b1011, 1'b1);
    check("t1_q", q0, Q_T1);
    check("t1_gap_valid", sv[0], 0);
    check("t1_gap_sout",  so[0], 0);
    check("t1_gap_busy",  bsy[0], 1);
    check("t1_gap_ready", rdy[0], 0);
    tick();
    check("t1_idle_busy",  bsy[0], 0);
    check("t1_idle_ready", rdy[0], 1);

    // 2: LSB first, 0001 -> 1,0,0,0 then one gap cycle of Busy
    send(1, 4'b0001);
    expect_frame(1, "t2", 4'b1000, 1'b1);
    cnt = 0;
    for (int g = 0; g < 40 && bsy[1]; g++) begin
      cnt++;
      tick();
    end
    check("t2_gap_len", cnt, 1);

    // 3: gap of 2, Load_valid held with 4'hF during frame 4'h3
    din[2] = 4'h3;
    lv[2]  = 1'b1;
    check("t3_ready0", rdy[2], 1);
    tick();
    din[2] = 4'hF;
    cnt  = 0;
    low  = 0;
    seen = '0;
    for (int g = 0; g < 40 && !rdy[2]; g++) begin
      if (sv[2]) seen = {seen[3:0], so[2]};
      else       low++;
      cnt++;
      tick();
    end
    check("t3_not_ready", cnt, NB + 2);
    check("t3_low_valid", low, 2);
    check("t3_bits", seen, T3_SEEN);
    tick();
    lv[2] = 1'b0;
    expect_frame(2, "t3b", 4'b1111, 1'b0);
    wait_idle(2);

    // 4: no gap, A then 5 back-to-back
    din[3] = 4'hA;
    lv[3]  = 1'b1;
    check("t4_ready0", rdy[3], 1);
    tick();
    din[3] = 4'h5;
    for (int k = 0; k < 2 * NB; k++) begin
      check("t4_valid", sv[3], 1);
      check("t4_sout",  so[3], B2B[2*NB-1-k]);
      check("t4_fs",    fs[3], (k == 0 || k == NB) ? 1 : 0);
      if (k == NB - 1) check("t4_ready_last", rdy[3], 1);
      tick();
      if (k == NB - 1) lv[3] = 1'b0;
    end
    check("t4_end_valid", sv[3], 0);
    check("t4_end_busy",  bsy[3], 0);

    // 5: async reset during bit 2 of 4'hC, then clean frame of 4'h9
    wait_idle(0);
    send(0, 4'hC);
    tick();
    check("t5_bit2", so[0], 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_sout",  so[0],  0);
    check("t5_rst_valid", sv[0],  0);
    check("t5_rst_fs",    fs[0],  0);
    check("t5_rst_busy",  bsy[0], 0);
    check("t5_rst_ready", rdy[0], 1);
    #2 rst_n = 1'b1;
    tick();
    check("t5_post_valid", sv[0], 0);
    send(0, 4'h9);
    expect_frame(0, "t5", 4'b1001, 1'b0);
    wait_idle(0);

    // 6: parity cases (data bits only without PISO_PARITY_EN)
    send(0, 4'b0111);
    expect_frame(0, "t6a", 4'b0111, 1'b1);
    wait_idle(0);
    send(0, 4'b0011);
    expect_frame(0, "t6b", 4'b0011, 1'b0);
    check("t6_end_valid", sv[0], 0);
    wait_idle(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
